// File: rtl/pll_dps_ctrl.sv
// PLL dynamic phase shift initiator: issues one phase_en pulse per requested step,
// handshakes each step on phase_done and tracks the net phase of one output counter.
module pll_dps_ctrl #(
    parameter int         STEP_W     = 8,
    parameter int         POS_W      = 16,
    parameter int         PULSE_LEN  = 2,
    parameter int         TIMEOUT    = 1023,
    parameter int         GAP_CYCLES = 2,
    parameter logic [4:0] TRACK_CNT  = 5'd0
) (
    input  logic              scanclk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [4:0]        i_req_cntsel,
    input  logic              i_req_updn,
    input  logic [STEP_W-1:0] i_req_steps,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [1:0]        o_err_code,
    output logic [STEP_W-1:0] o_steps_done,
    output logic [POS_W-1:0]  o_position,
    input  logic              pll_locked,
    output logic              phase_en,
    output logic              updn,
    output logic [4:0]        cntsel,
    input  logic              phase_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_WAIT_LOW, S_WAIT_HIGH, S_GAP, S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0, ERR_TIMEOUT = 2'd1, ERR_LOCK = 2'd2, ERR_ABORT = 2'd3
    } err_t;

    localparam int CNT_MAX_A = (TIMEOUT > PULSE_LEN) ? TIMEOUT : PULSE_LEN;
    localparam int CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    state_t              r_state;
    state_t              w_next;
    err_t                r_err_code;
    err_t                w_err;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_pd_meta;
    logic                r_pd_s;
    logic                r_phase_en;
    logic                r_done;
    logic                r_error;
    logic                r_updn;
    logic [4:0]          r_cntsel;
    logic [STEP_W-1:0]   r_steps_req;
    logic [STEP_W-1:0]   r_steps_done;
    logic [POS_W-1:0]    r_position;
    logic                w_accept;
    logic                w_zero_accept;
    logic                w_in_run;
    logic                w_tmo_hit;
    logic                w_pd_step;
    logic                w_count;
    logic                w_last;

    assign o_req_ready   = (r_state == S_IDLE) && pll_locked;
    assign w_accept      = i_req_valid && o_req_ready;
    assign w_zero_accept = w_accept && (i_req_steps == '0);
    assign w_in_run      = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign w_tmo_hit     = ((r_state == S_WAIT_LOW) || (r_state == S_WAIT_HIGH))
                           && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_pd_step     = (r_state == S_WAIT_HIGH) && r_pd_s;
    assign w_last        = (r_steps_done + STEP_W'(1)) == r_steps_req;

    // Normal sequencing first, then fault overrides in priority order:
    // lock lost > abort > timeout. An abort coinciding with a phase_done rise
    // still counts that step; lock loss and timeout do not.
    always_comb begin
        // NOTE: every always_comb output gets a default up front so no path can infer a latch.
        w_next  = r_state;
        w_err   = ERR_NONE;
        w_count = w_pd_step;
        unique case (r_state)
            S_IDLE:      if (w_accept && !w_zero_accept) w_next = S_SETUP;
            S_SETUP:     w_next = S_PULSE;
            S_PULSE:     if (r_cnt == CNT_W'(PULSE_LEN - 1)) w_next = S_WAIT_LOW;
            S_WAIT_LOW:  if (!r_pd_s) w_next = S_WAIT_HIGH;
            S_WAIT_HIGH: if (r_pd_s) w_next = w_last ? S_FINISH
                                          : ((GAP_CYCLES == 0) ? S_SETUP : S_GAP);
            S_GAP:       if (r_cnt == CNT_W'(GAP_CYCLES - 1)) w_next = S_SETUP;
            S_FINISH:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
        if (w_in_run) begin
            if (!pll_locked) begin
                w_next  = S_FINISH;
                w_err   = ERR_LOCK;
                w_count = 1'b0;
            end else if (i_abort) begin
                w_next = S_FINISH;
                w_err  = ERR_ABORT;
            end else if (w_tmo_hit) begin
                w_next  = S_FINISH;
                w_err   = ERR_TIMEOUT;
                w_count = 1'b0;
            end
        end
    end

    // NOTE: synchronizer flops carry no reset; they only ever hold a sampled copy of phase_done.
    always_ff @(posedge scanclk) begin
        r_pd_meta <= phase_done;
        r_pd_s    <= r_pd_meta;
    end

    always_ff @(posedge scanclk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_phase_en   <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_updn       <= 1'b0;
            r_cntsel     <= '0;
            r_steps_req  <= '0;
            r_steps_done <= '0;
            r_position   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state    <= w_next;
            r_cnt      <= ((w_next != r_state) || (r_state == S_IDLE)) ? '0 : r_cnt + CNT_W'(1);
            r_phase_en <= (w_next == S_PULSE);
            r_done     <= (w_next == S_FINISH) || w_zero_accept;
            if (w_accept) begin
                r_cntsel     <= i_req_cntsel;
                r_updn       <= i_req_updn;
                r_steps_req  <= i_req_steps;
                r_error      <= 1'b0;
                r_err_code   <= ERR_NONE;
                r_steps_done <= '0;
            end
            if (w_count) begin
                r_steps_done <= r_steps_done + STEP_W'(1);
                if (r_cntsel == TRACK_CNT)
                    r_position <= r_position + (r_updn ? POS_W'(1) : {POS_W{1'b1}});
            end
            if (w_err != ERR_NONE) begin
                r_error    <= 1'b1;
                r_err_code <= w_err;
            end
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_err_code   = r_err_code;
    assign o_steps_done = r_steps_done;
    assign o_position   = r_position;
    assign phase_en     = r_phase_en;
    assign updn         = r_updn;
    assign cntsel       = r_cntsel;

endmodule

// File: tb/tb_pll_dps_ctrl.sv
// Self-checking bench for pll_dps_ctrl: behavioural PLL phase_done model, pulse monitor,
// and a request-level reference model for position, step count and error code.
module tb_pll_dps_ctrl;

    localparam int         STEP_W     = 8;
    localparam int         POS_W      = 16;
    localparam int         PULSE_LEN  = 2;
    localparam int         TIMEOUT    = 1023;
    localparam int         GAP_CYCLES = 2;
    localparam logic [4:0] TRACK_CNT  = 5'd0;

    logic              scanclk;
    logic              rst;
    logic              i_req_valid;
    logic              o_req_ready;
    logic [4:0]        i_req_cntsel;
    logic              i_req_updn;
    logic [STEP_W-1:0] i_req_steps;
    logic              i_abort;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
    logic [1:0]        o_err_code;
    logic [STEP_W-1:0] o_steps_done;
    logic [POS_W-1:0]  o_position;
    logic              pll_locked;
    logic              phase_en;
    logic              updn;
    logic [4:0]        cntsel;
    logic              phase_done;

    pll_dps_ctrl #(
        .STEP_W(STEP_W), .POS_W(POS_W), .PULSE_LEN(PULSE_LEN),
        .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES), .TRACK_CNT(TRACK_CNT)
    ) dut (
        .scanclk(scanclk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_cntsel(i_req_cntsel), .i_req_updn(i_req_updn), .i_req_steps(i_req_steps),
        .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_err_code(o_err_code), .o_steps_done(o_steps_done), .o_position(o_position),
        .pll_locked(pll_locked), .phase_en(phase_en), .updn(updn), .cntsel(cntsel),
        .phase_done(phase_done)
    );

    initial begin
        scanclk = 1'b0;
        forever #5 scanclk = ~scanclk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    // PLL model controls and request-level reference state
    int               pll_steps    = 0;
    int               lock_drop_at = -1;
    int               abort_at     = -1;
    int               pd_low       = 4;
    bit               pd_stuck     = 1'b0;
    logic [POS_W-1:0] exp_pos;
    logic [4:0]       exp_sel;
    logic             exp_ud;

    // Pulse monitor statistics, cleared per request
    int mon_hi = 0;
    int mon_lo = 0;
    int mon_min_gap = 0;
    int mon_len_bad = 0;
    int mon_sel_bad = 0;
    bit mon_seen = 1'b0;

    // Behavioural PLL: phase_done falls one cycle after phase_en drops, stays low pd_low cycles.
    initial begin
        phase_done = 1'b1;
        forever begin
            @(negedge scanclk);
            if (phase_en) begin
                pll_steps++;
                if (pll_steps == lock_drop_at) pll_locked = 1'b0;
                while (phase_en) @(negedge scanclk);
                if (!pd_stuck) begin
                    phase_done = 1'b0;
                    repeat (pd_low) @(negedge scanclk);
                    phase_done = 1'b1;
                    if (pll_steps == abort_at) begin
                        // Land i_abort on the edge where the synchronized phase_done is first high.
                        @(negedge scanclk);
                        @(negedge scanclk);
                        i_abort = 1'b1;
                        @(negedge scanclk);
                        i_abort = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge scanclk);
            if (phase_en) begin
                if (mon_hi == 0 && mon_seen && mon_lo < mon_min_gap) mon_min_gap = mon_lo;
                mon_hi++;
                mon_seen = 1'b1;
                mon_lo   = 0;
                if (cntsel !== exp_sel || updn !== exp_ud) mon_sel_bad++;
            end else begin
                if (mon_hi != 0 && mon_hi != PULSE_LEN) mon_len_bad++;
                mon_hi = 0;
                mon_lo++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [4:0] sel, input logic ud, input logic [STEP_W-1:0] st);
        int n;
        n = 0;
        @(negedge scanclk);
        while ((!o_req_ready || !phase_done) && n < 200) begin
            @(negedge scanclk);
            n++;
        end
        check("req_ready", o_req_ready, 1);
        exp_sel     = sel;
        exp_ud      = ud;
        mon_len_bad = 0;
        mon_sel_bad = 0;
        mon_min_gap = 1000000;
        mon_seen    = 1'b0;
        i_req_valid  = 1'b1;
        i_req_cntsel = sel;
        i_req_updn   = ud;
        i_req_steps  = st;
        @(negedge scanclk);
        i_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!o_done && n < 4000) begin
            @(negedge scanclk);
            n++;
        end
        check("done_seen", o_done, 1);
    endtask

    task automatic run_normal(input logic [4:0] sel, input logic ud, input logic [STEP_W-1:0] st);
        int base;
        base = pll_steps;
        issue(sel, ud, st);
        check("err_cleared_on_accept", o_error, 0);
        if (st == 0) begin
            check("zero_done_next_cycle", o_done, 1);
            check("zero_busy", o_busy, 0);
        end else begin
            check("setup_phase_en", phase_en, 0);
            check("setup_cntsel", cntsel, sel);
            check("setup_updn", updn, ud);
        end
        wait_done();
        if (sel == TRACK_CNT)
            exp_pos = ud ? exp_pos + POS_W'(st) : exp_pos - POS_W'(st);
        check("steps_done", o_steps_done, st);
        check("err_code", o_err_code, 0);
        check("error", o_error, 0);
        check("position", o_position, exp_pos);
        check("pulse_count", pll_steps - base, st);
        check("pulse_len_bad", mon_len_bad, 0);
        check("sel_unstable", mon_sel_bad, 0);
        if (st >= 2) check("gap_min_ok", mon_min_gap >= GAP_CYCLES + 1, 1);
        @(negedge scanclk);
        check("done_one_cycle", o_done, 0);
        check("idle_busy", o_busy, 0);
        check("hold_cntsel", cntsel, sel);
        check("hold_updn", updn, ud);
    endtask

    initial begin
        int n;
        int base;
        int cnt;
        int wcnt;
        bit seen;
        bit done;
        logic [4:0] sel;
        logic ud;
        logic [STEP_W-1:0] st;

        rst          = 1'b1;
        i_req_valid  = 1'b0;
        i_req_cntsel = '0;
        i_req_updn   = 1'b0;
        i_req_steps  = '0;
        i_abort      = 1'b0;
        pll_locked   = 1'b1;
        exp_pos      = '0;
        exp_sel      = '0;
        exp_ud       = 1'b0;
        repeat (3) @(negedge scanclk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_phase_en", phase_en, 0);
        check("rst_position", o_position, 0);
        check("rst_err_code", o_err_code, 0);
        check("rst_error", o_error, 0);
        check("rst_steps_done", o_steps_done, 0);
        check("rst_cntsel", cntsel, 0);
        check("rst_ready", o_req_ready, 1);
        rst = 1'b0;

        pd_low = 4;
        run_normal(5'd0, 1'b1, 8'd1);
        check("single_up_pos", o_position, 16'h0001);
        run_normal(5'd0, 1'b0, 8'd5);
        check("multi_down_pos", o_position, 16'hFFFC);
        run_normal(5'd1, 1'b1, 8'd3);
        run_normal(5'd0, 1'b1, 8'd0);

        // Timeout: phase_done never falls
        pd_stuck = 1'b1;
        base = pll_steps;
        issue(5'd0, 1'b1, 8'd2);
        seen = 1'b0; done = 1'b0; wcnt = 0; n = 0;
        while (!done && n < 4000) begin
            if (o_done) done = 1'b1;
            else begin
                if (phase_en) seen = 1'b1;
                else if (seen) wcnt++;
                @(negedge scanclk);
                n++;
            end
        end
        check("tmo_done_seen", done, 1);
        check("tmo_wait_cycles", wcnt, TIMEOUT);
        check("tmo_err_code", o_err_code, 1);
        check("tmo_error", o_error, 1);
        check("tmo_steps_done", o_steps_done, 0);
        check("tmo_position", o_position, exp_pos);
        check("tmo_pulses", pll_steps - base, 1);
        pd_stuck = 1'b0;
        run_normal(5'd2, 1'b0, 8'd1);

        // Lock loss during the third pulse of ten
        lock_drop_at = pll_steps + 3;
        issue(5'd0, 1'b1, 8'd10);
        n = 0;
        while (pll_locked && n < 2000) begin
            @(posedge scanclk);
            n++;
        end
        @(negedge scanclk);
        check("lock_phase_en_low", phase_en, 0);
        check("lock_done", o_done, 1);
        check("lock_err_code", o_err_code, 2);
        check("lock_error", o_error, 1);
        check("lock_steps_done", o_steps_done, 2);
        exp_pos = exp_pos + POS_W'(2);
        check("lock_position", o_position, exp_pos);
        lock_drop_at = -1;
        cnt = 0;
        repeat (6) begin
            @(negedge scanclk);
            if (o_req_ready) cnt++;
        end
        check("lock_ready_held_low", cnt, 0);
        pll_locked = 1'b1;
        @(negedge scanclk);
        check("lock_ready_back", o_req_ready, 1);

        // Abort coinciding with the synchronized phase_done rise of step 4
        pd_low   = 4;
        ud       = 1'($urandom_range(0, 1));
        abort_at = pll_steps + 4;
        issue(5'd0, ud, 8'd6);
        wait_done();
        check("abort_steps_done", o_steps_done, 4);
        check("abort_err_code", o_err_code, 3);
        check("abort_error", o_error, 1);
        exp_pos = ud ? exp_pos + POS_W'(4) : exp_pos - POS_W'(4);
        check("abort_position", o_position, exp_pos);
        abort_at = -1;

        // Randomized requests against the request-level model
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0:       sel = TRACK_CNT;
                1:       sel = 5'd1;
                default: sel = 5'($urandom_range(0, 31));
            endcase
            ud     = 1'($urandom_range(0, 1));
            st     = STEP_W'($urandom_range(0, 7));
            pd_low = $urandom_range(2, 6);
            run_normal(sel, ud, st);
        end

        // Reset while waiting for phase_done to rise
        pd_low = 4;
        run_normal(5'd0, 1'b1, 8'd5);
        pd_low = 6;
        issue(5'd0, 1'b1, 8'd3);
        n = 0;
        while (phase_done && n < 200) begin
            @(posedge scanclk);
            n++;
        end
        repeat (2) @(posedge scanclk);
        @(negedge scanclk);
        rst = 1'b1;
        @(negedge scanclk);
        check("midrst_busy", o_busy, 0);
        check("midrst_phase_en", phase_en, 0);
        check("midrst_position", o_position, 0);
        check("midrst_done", o_done, 0);
        rst = 1'b0;
        exp_pos = '0;
        cnt = 0;
        repeat (8) begin
            @(negedge scanclk);
            if (o_done) cnt++;
        end
        check("midrst_no_done", cnt, 0);
        pd_low = 4;
        run_normal(5'd0, 1'b0, 8'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
